seq_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector path. Accepts words from a producer over a valid/ready handshake and shifts them out one bit per bit period. The selected bit order is MSB-first or LSB-first, chosen per word. `serial_out` drives the detector's `sequence_in` directly. Optional inter-word gap and a bit-rate strobe let the bench and system pace the stream.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_serializer.sv | 122 ++++++++++++
 tb/tb_seq_serializer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end: FSM encodings
// and a bit-order helper used when loading LSB-first words.
package seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_GAP   = ST_GAP
   } ser_state_t;

   // Reverse the low 'width' bits of w; bits at and above 'width' come back as 0.
   // The 32-bit container covers every legal word width.
   function automatic logic [31:0] bit_reverse(input logic [31:0] w, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) r[i] = w[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: takes words over valid/ready and shifts them
// out one bit per bit period, MSB-first or LSB-first per word, with an
// optional idle gap between words.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             msb_first,
   input  logic             bit_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   ser_state_t       state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    bit_cnt;
   logic [3:0]       gap_cnt;

   logic [31:0]      word_ext;
   logic [WIDTH-1:0] word_rev;
   logic [WIDTH-1:0] load_word;
   logic             accept;

   // Always shift out of the MSB; LSB-first words are reversed on load.
   always_comb begin
      word_ext              = '0;
      word_ext[WIDTH-1:0]   = word_in;
      word_rev              = WIDTH'(bit_reverse(word_ext, WIDTH));
      load_word             = msb_first ? word_in : word_rev;
   end

   // Ready in IDLE, or on the final bit when words may run back to back.
   // Held low while reset is asserted.
   always_comb begin
      word_ready = reset &&
                   ((state == S_IDLE) ||
                    ((state == S_SHIFT) && (bit_cnt == '0) && bit_en && (GAP_CYCLES == 0)));
      accept     = word_valid && word_ready;
   end

   // Valid and last-bit flags decode straight from registered state.
   always_comb begin
      serial_valid = (state == S_SHIFT);
      last_bit     = (state == S_SHIFT) && (bit_cnt == '0);
   end

   // Serializer FSM; serial_out and busy are registered alongside the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         serial_out <= IDLE_LEVEL;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sr         <= load_word;
                  bit_cnt    <= CNT_LOAD;
                  serial_out <= load_word[WIDTH-1];
                  busy       <= 1'b1;
                  state      <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_en) begin
                  if (bit_cnt != '0) begin
                     sr         <= sr << 1;
                     bit_cnt    <= bit_cnt - 1'b1;
                     serial_out <= sr[WIDTH-2];
                  end else if (GAP_CYCLES > 0) begin
                     gap_cnt    <= GAP_LOAD;
                     serial_out <= IDLE_LEVEL;
                     state      <= S_GAP;
                  end else if (accept) begin
                     // next word follows with no bubble
                     sr         <= load_word;
                     bit_cnt    <= CNT_LOAD;
                     serial_out <= load_word[WIDTH-1];
                  end else begin
                     serial_out <= IDLE_LEVEL;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (bit_en) begin
                  if (gap_cnt == '0) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
            end
            default: begin
               serial_out <= IDLE_LEVEL;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, both bit orders, back-to-back
// words, inter-word gap, bit_en pacing and asynchronous reset mid-word.
module tb_seq_serializer;

   logic       clock;
   logic       reset;
   logic [7:0] word_in;
   logic       word_valid;
   logic       msb_first;
   logic       bit_en;

   logic so0, sv0, lb0, bz0, rdy0;
   logic so1, sv1, lb1, bz1, rdy1;

   int n_chk;
   int n_fail;

   seq_serializer #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
      .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
      .word_ready(rdy0), .msb_first(msb_first), .bit_en(bit_en),
      .serial_out(so0), .serial_valid(sv0), .last_bit(lb0), .busy(bz0)
   );

   seq_serializer #(.WIDTH(8), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) dut1 (
      .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
      .word_ready(rdy1), .msb_first(msb_first), .bit_en(bit_en),
      .serial_out(so1), .serial_valid(sv1), .last_bit(lb1), .busy(bz1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  pat8;
      logic [15:0] pat16;
      n_chk      = 0;
      n_fail     = 0;
      reset      = 1'b0;
      word_in    = 8'h00;
      word_valid = 1'b0;
      msb_first  = 1'b1;
      bit_en     = 1'b1;

      // ---- reset held 3 cycles
      repeat (3) tick();
      chk("rst_serial_out", so0, 0);
      chk("rst_serial_valid", sv0, 0);
      chk("rst_last_bit", lb0, 0);
      chk("rst_busy", bz0, 0);
      chk("rst_word_ready", rdy0, 0);
      reset = 1'b1;
      #1;
      chk("post_rst_ready", rdy0, 1);
      tick();

      // ---- MSB-first 8'hA5 -> 1,0,1,0,0,1,0,1
      pat8       = 8'b10100101;
      word_in    = 8'hA5;
      msb_first  = 1'b1;
      word_valid = 1'b1;
      #1;
      chk("msb_ready", rdy0, 1);
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("msb_valid%0d", i), sv0, 1);
         chk($sformatf("msb_bit%0d", i), so0, pat8[7-i]);
         chk($sformatf("msb_last%0d", i), lb0, (i == 7) ? 1 : 0);
         tick();
      end
      chk("msb_done_valid", sv0, 0);
      chk("msb_done_busy", bz0, 0);

      // ---- LSB-first 8'h0F -> 1,1,1,1,0,0,0,0
      pat8       = 8'b11110000;
      word_in    = 8'h0F;
      msb_first  = 1'b0;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb_bit%0d", i), so0, pat8[7-i]);
         chk($sformatf("lsb_busy%0d", i), bz0, 1);
         tick();
      end
      chk("lsb_n9_valid", sv0, 0);
      chk("lsb_n9_out", so0, 0);

      // ---- back-to-back 8'hA5 then 8'h3C, no bubble
      pat16      = 16'b1010_0101_0011_1100;
      word_in    = 8'hA5;
      msb_first  = 1'b1;
      word_valid = 1'b1;
      tick();
      word_in    = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("b2b_valid%0d", i), sv0, 1);
         chk($sformatf("b2b_bit%0d", i), so0, pat16[15-i]);
         if (i == 7) begin
            chk("b2b_ready_n8", rdy0, 1);
            chk("b2b_last_n8", lb0, 1);
         end
         tick();
         if (i == 7) word_valid = 1'b0;
      end
      chk("b2b_end_valid", sv0, 0);
      chk("b2b_end_busy", bz0, 0);

      // ---- gap of 3 bit periods on the GAP_CYCLES=3 instance
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      word_in    = 8'hA5;
      msb_first  = 1'b1;
      word_valid = 1'b1;
      #1;
      chk("gap_ready0", rdy1, 1);
      tick();
      word_in = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("gap_w0_valid%0d", i), sv1, 1);
         chk($sformatf("gap_w0_ready%0d", i), rdy1, 0);
         tick();
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("gap_valid%0d", g), sv1, 0);
         chk($sformatf("gap_out%0d", g), so1, 0);
         chk($sformatf("gap_ready%0d", g), rdy1, 0);
         chk($sformatf("gap_busy%0d", g), bz1, 1);
         tick();
      end
      chk("gap_idle_ready", rdy1, 1);
      chk("gap_idle_busy", bz1, 0);
      chk("gap_idle_valid", sv1, 0);
      tick();
      word_valid = 1'b0;
      pat8 = 8'b00111100;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("gap_w1_bit%0d", i), so1, pat8[7-i]);
         chk($sformatf("gap_w1_valid%0d", i), sv1, 1);
         tick();
      end

      // ---- bit_en pacing, then reset mid-word
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      pat8       = 8'b10100101;
      word_in    = 8'hA5;
      msb_first  = 1'b1;
      word_valid = 1'b1;
      bit_en     = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bit_en = (k % 2 == 1);
         chk($sformatf("pace_bit%0d", k), so0, pat8[7-(k/2)]);
         chk($sformatf("pace_valid%0d", k), sv0, 1);
         tick();
      end
      // now presenting bit 4 (index 3 of 8'hA5 = 0)
      chk("pace_bit4", so0, 0);
      chk("pace_bit4_valid", sv0, 1);
      reset = 1'b0;
      #1;
      chk("arst_valid", sv0, 0);
      chk("arst_busy", bz0, 0);
      chk("arst_ready", rdy0, 0);
      chk("arst_out", so0, 0);
      chk("arst_last", lb0, 0);
      tick();
      tick();
      reset  = 1'b1;
      bit_en = 1'b1;
      #1;
      chk("arst_rel_ready", rdy0, 1);
      pat8       = 8'b11110000;
      word_in    = 8'hF0;
      msb_first  = 1'b1;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("f0_bit%0d", i), so0, pat8[7-i]);
         chk($sformatf("f0_last%0d", i), lb0, (i == 7) ? 1 : 0);
         tick();
      end
      chk("f0_end_valid", sv0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
